// File: rtl/mult_div_seq.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_seq
// Description : Iterative 32x32 multiplier / 32/32 divider for the EX stage.
//               One shift-add (MULT/MULTU) or restoring shift-subtract
//               (DIV/DIVU) step per cycle over 32 cycles; result is {hi, lo}.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  funct,
  input  logic [31:0] operand_1,
  input  logic [31:0] operand_2,
  input  logic        flush,
  input  logic        pipe_stall,
  output logic        mult_div_done,
  output logic [63:0] mult_div_result,
  output logic        busy
);

  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  // Mult: {partial product, remaining multiplier bits}.
  // Div : {partial remainder, dividend bits becoming quotient bits}.
  logic [63:0] work_q, work_d;
  // Multiplicand magnitude (mult) or divisor magnitude (div).
  logic [31:0] opb_q, opb_d;
  logic        neg_res_q, neg_res_d;
  logic        neg_rem_q, neg_rem_d;
  logic [63:0] result_q, result_d;

  // Issue decode and operand magnitudes
  logic        is_mult, is_div, is_signed, sign1, sign2;
  logic [31:0] mag1, mag2;

  assign is_mult   = (funct == FUNCT_MULT) || (funct == FUNCT_MULTU);
  assign is_div    = (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
  assign is_signed = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
  assign sign1     = is_signed & operand_1[31];
  assign sign2     = is_signed & operand_2[31];
  // Negating 0x80000000 yields 0x80000000, which is the correct unsigned magnitude.
  assign mag1      = sign1 ? (32'd0 - operand_1) : operand_1;
  assign mag2      = sign2 ? (32'd0 - operand_2) : operand_2;

  // One shift-add multiply step: add multiplicand into the upper half when the
  // current multiplier LSB is set, then shift the whole register right.
  logic [32:0] mult_sum;
  logic [63:0] mult_next;
  assign mult_sum  = {1'b0, work_q[63:32]} + (work_q[0] ? {1'b0, opb_q} : 33'd0);
  assign mult_next = {mult_sum, work_q[31:1]};

  // One restoring divide step: shift the next dividend bit into the remainder
  // and subtract the divisor if it fits. When it fits the true difference is
  // below the divisor, so the low 32 bits of the subtraction are exact.
  logic [32:0] div_tmp;
  logic        div_ge;
  logic [31:0] div_sub;
  logic [63:0] div_next;
  assign div_tmp  = {work_q[63:32], work_q[31]};
  assign div_ge   = (div_tmp >= {1'b0, opb_q});
  assign div_sub  = div_tmp[31:0] - opb_q;
  assign div_next = div_ge ? {div_sub,       work_q[30:0], 1'b1}
                           : {div_tmp[31:0], work_q[30:0], 1'b0};

  // Sign-corrected final results taken from the last step's output
  logic [63:0] mult_final;
  logic [31:0] quo_final, rem_final;
  assign mult_final = neg_res_q ? (64'd0 - mult_next) : mult_next;
  assign quo_final  = neg_res_q ? (32'd0 - div_next[31:0]) : div_next[31:0];
  assign rem_final  = neg_rem_q ? (32'd0 - div_next[63:32]) : div_next[63:32];

  // Next-state and datapath update; flush overrides everything else
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    opb_d     = opb_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;

    case (state_q)
      S_IDLE: begin
        if (is_mult || is_div) begin
          cnt_d     = 5'd0;
          neg_res_d = sign1 ^ sign2;
          neg_rem_d = sign1;
          if (is_mult) begin
            work_d  = {32'd0, mag2};
            opb_d   = mag1;
            state_d = S_MULT;
          end else if (operand_2 == 32'd0) begin
            result_d = {operand_1, 32'hFFFF_FFFF};
            state_d  = S_DONE;
          end else begin
            work_d  = {32'd0, mag1};
            opb_d   = mag2;
            state_d = S_DIV;
          end
        end
      end
      S_MULT: begin
        work_d = mult_next;
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          result_d = mult_final;
          state_d  = S_DONE;
        end
      end
      S_DIV: begin
        work_d = div_next;
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          result_d = {rem_final, quo_final};
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (!pipe_stall) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A cancelled operation must neither complete nor disturb the held result.
    if (flush) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 5'd0;
      work_q    <= 64'd0;
      opb_q     <= 32'd0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= 64'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      opb_q     <= opb_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  assign mult_div_done   = (state_q == S_DONE);
  assign busy            = (state_q == S_MULT) || (state_q == S_DIV);
  assign mult_div_result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_div_seq
// Description : Scoreboard bench for mult_div_seq. Stimulus pushes the
//               hand-computed result and expected done cycle; a monitor pops
//               and compares on every rising edge of mult_div_done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_seq;

  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_NOP   = 6'h20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  funct = F_NOP;
  logic [31:0] operand_1 = 32'd0;
  logic [31:0] operand_2 = 32'd0;
  logic        flush = 1'b0;
  logic        pipe_stall = 1'b0;
  logic        mult_div_done;
  logic [63:0] mult_div_result;
  logic        busy;

  mult_div_seq dut (
    .clk             (clk),
    .rst             (rst),
    .funct           (funct),
    .operand_1       (operand_1),
    .operand_2       (operand_2),
    .flush           (flush),
    .pipe_stall      (pipe_stall),
    .mult_div_done   (mult_div_done),
    .mult_div_result (mult_div_result),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] res;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   issue_cyc;
  logic done_prev = 1'b0;

  // Monitor: one scoreboard entry per done pulse, checked for value and timing
  always @(negedge clk) begin
    if (mult_div_done && !done_prev) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done cyc=%0d result=%h required=no done", cyc, mult_div_result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (mult_div_result !== e.res) begin
          failures++;
          $display("FAIL result got=%h required=%h", mult_div_result, e.res);
        end
        checks++;
        if (cyc != e.cyc) begin
          failures++;
          $display("FAIL done_cycle got=%0d required=%0d", cyc, e.cyc);
        end
      end
    end
    done_prev <= mult_div_done;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h required=%h", name, got, want);
    end
  endtask

  // Present an op for one cycle, then junk (must be ignored) for one cycle,
  // then a non-mult/div code. lat is counted from the presentation cycle.
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] res, input int lat, input bit push);
    exp_t e;
    @(negedge clk);
    funct = f; operand_1 = a; operand_2 = b;
    issue_cyc = cyc;
    if (push) begin
      e.res = res;
      e.cyc = cyc + lat;
      sb.push_back(e);
    end
    @(negedge clk);
    funct = F_DIVU; operand_1 = $urandom; operand_2 = $urandom;
    @(negedge clk);
    funct = F_NOP;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL timeout got=%0d pending required=0 pending", sb.size());
      sb.delete();
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [63:0] held;
    int n;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_done",   {63'd0, mult_div_done}, 64'd0);
    check("reset_busy",   {63'd0, busy},          64'd0);
    check("reset_result", mult_div_result,        64'd0);

    // Directed vectors
    issue(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 33, 1); drain();
    issue(F_MULT,  32'hFFFF_FFFD, 32'd7,         64'hFFFF_FFFF_FFFF_FFEB, 33, 1); drain();
    issue(F_DIV,   32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD, 33, 1); drain();
    issue(F_MULT,  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 33, 1); drain();
    issue(F_DIVU,  32'd7,         32'd2,         64'h0000_0001_0000_0003, 33, 1); drain();
    issue(F_DIVU,  32'd5,         32'd0,         64'h0000_0005_FFFF_FFFF,  1, 1); drain();
    issue(F_DIV,   32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 33, 1); drain();
    issue(F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 33, 1); drain();
    issue(F_DIV,   32'hFFFF_FFFB, 32'd0,         64'hFFFF_FFFB_FFFF_FFFF,  1, 1); drain();
    issue(F_MULTU, 32'd0,         32'h0001_2345, 64'h0,                   33, 1); drain();

    // Flush at iteration 10 of a DIV: no done, then a fresh MULTU
    issue(F_DIVU, 32'd100, 32'd7, 64'h0, 0, 0);
    while (cyc < issue_cyc + 6) @(negedge clk);
    check("busy_mid_op", {63'd0, busy}, 64'd1);
    while (cyc < issue_cyc + 11) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", {63'd0, busy},          64'd0);
    check("flush_done", {63'd0, mult_div_done}, 64'd0);
    idle_cycles(40);
    issue(F_MULTU, 32'd3, 32'd4, 64'h0000_0000_0000_000C, 33, 1); drain();

    // Done held under pipe_stall
    pipe_stall = 1'b1;
    issue(F_MULT, 32'd6, 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFF4, 33, 1);
    n = 0;
    while (!mult_div_done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("stall_reached_done", {63'd0, mult_div_done}, 64'd1);
    held = 64'hFFFF_FFFF_FFFF_FFF4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_done",   {63'd0, mult_div_done}, 64'd1);
      check("stall_result", mult_div_result,        held);
      check("stall_busy",   {63'd0, busy},          64'd0);
    end
    pipe_stall = 1'b0;
    @(negedge clk);
    check("unstall_done", {63'd0, mult_div_done}, 64'd0);
    check("unstall_busy", {63'd0, busy},          64'd0);
    check("unstall_hold", mult_div_result,        held);
    drain();

    // Reset at iteration 20 of a MULT: no done, result cleared
    issue(F_MULTU, 32'd3, 32'd5, 64'h0, 0, 0);
    while (cyc < issue_cyc + 21) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_done",   {63'd0, mult_div_done}, 64'd0);
    check("rst_mid_busy",   {63'd0, busy},          64'd0);
    check("rst_mid_result", mult_div_result,        64'd0);
    idle_cycles(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
